// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_pkg
//  Description : Shared types and helpers for the byte-lane RAM with a
//                clear engine (read-during-write modes, FSM states, lane count).
//  Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_pkg;

    // Read-during-write behaviour of the single port
    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } rdw_mode_e;

    // Clear engine states
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // Number of byte lanes in a word
    function automatic int lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram_core.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_core
//  Description : Storage array with a lane-masked write port and a single
//                registered read port; the read-during-write mux selects the
//                old or the merged word on writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_core
    import sp_ram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int LANE_W   = 8,
    parameter int RDW_MODE = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_wr_en,
    input  logic                               i_rd_en,
    input  logic [lanes(DATA_W, LANE_W)-1:0]   i_be,
    input  logic [ADDR_W-1:0]                  i_addr,
    input  logic [DATA_W-1:0]                  i_wdata,
    output logic [DATA_W-1:0]                  o_rdata
);

    localparam int        c_DEPTH = 2 ** ADDR_W;
    localparam int        c_LANES = lanes(DATA_W, LANE_W);
    localparam rdw_mode_e c_RDW   = rdw_mode_e'(RDW_MODE[1:0]);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] r_q;

    assign w_old = r_mem[i_addr];

    // Word as it looks after the lane-masked write
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < c_LANES; i++) begin
            if (i_be[i]) begin
                w_merged[i*LANE_W +: LANE_W] = i_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Lane-masked write port; the array itself is never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_LANES; i++) begin
            if (i_wr_en && i_be[i]) begin
                r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Registered read port; holds its value when no read result is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_rd_en) begin
            if (i_wr_en && (c_RDW == WRITE_FIRST)) begin
                r_q <= w_merged;
            end else begin
                r_q <= w_old;
            end
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/sp_ram_be_clr.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_be_clr
//  Description : Parametrised single-port RAM with byte-lane write enables,
//                selectable read-during-write mode, optional output register
//                and a clear engine that fills the array after reset or on
//                request.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_be_clr
    import sp_ram_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 6,
    parameter int                LANE_W    = 8,
    parameter int                RDW_MODE  = 0,
    parameter int                OUT_REG   = 0,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               we,
    input  logic [lanes(DATA_W, LANE_W)-1:0]   be,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [DATA_W-1:0]                  wdata,
    input  logic                               clr,
    output logic                               ready,
    output logic [DATA_W-1:0]                  rdata,
    output logic                               rvalid,
    output logic                               clr_done
);

    localparam int        c_LANES = lanes(DATA_W, LANE_W);
    localparam rdw_mode_e c_RDW   = rdw_mode_e'(RDW_MODE[1:0]);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [ADDR_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]    w_ptr_nxt;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_flush;
    logic                 r_clr_done;
    logic                 r_v1;

    logic                 w_core_wr;
    logic                 w_core_rd;
    logic [c_LANES-1:0]   w_core_be;
    logic [ADDR_W-1:0]    w_core_addr;
    logic [DATA_W-1:0]    w_core_wdata;
    logic [DATA_W-1:0]    w_core_q;

    assign ready    = (r_state == IDLE);
    assign w_last   = (r_ptr == {ADDR_W{1'b1}});
    // clr wins over a concurrent access; reset also drops it
    assign w_accept = en && ready && !clr && !rst;
    // Entering CLEAR kills any read result still in flight
    assign w_flush  = (r_state == IDLE) && clr;

    // State and clear pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state: sweep every address once, then serve accesses until clr
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Port arbitration: the clear engine owns the array while clearing
    always_comb begin
        w_core_wr    = 1'b0;
        w_core_rd    = 1'b0;
        w_core_be    = be;
        w_core_addr  = addr;
        w_core_wdata = wdata;
        if (!rst) begin
            if (r_state == CLEAR) begin
                w_core_wr    = 1'b1;
                w_core_be    = '1;
                w_core_addr  = r_ptr;
                w_core_wdata = CLR_VALUE;
            end else if (w_accept) begin
                w_core_wr = we;
                w_core_rd = !we || (c_RDW != NO_CHANGE);
            end
        end
    end

    sp_ram_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LANE_W   (LANE_W),
        .RDW_MODE (RDW_MODE)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_core_wr),
        .i_rd_en (w_core_rd),
        .i_be    (w_core_be),
        .i_addr  (w_core_addr),
        .i_wdata (w_core_wdata),
        .o_rdata (w_core_q)
    );

    // First stage of the valid pipeline, aligned with the core read register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_core_rd && !w_flush;
        end
    end

    // One-cycle pulse after the final clear write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= (r_state == CLEAR) && w_last;
        end
    end

    assign clr_done = r_clr_done;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_v2;
            logic [DATA_W-1:0] r_out;

            // Extra output stage; flushed on entry to CLEAR
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2  <= 1'b0;
                    r_out <= '0;
                end else begin
                    r_v2 <= r_v1 && !w_flush;
                    if (r_v1 && !w_flush) begin
                        r_out <= w_core_q;
                    end
                end
            end

            assign rdata  = r_out;
            assign rvalid = r_v2;
        end else begin : g_no_out_reg
            assign rdata  = w_core_q;
            assign rvalid = r_v1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_be_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ram_be_clr
//  Description : Self-checking bench for sp_ram_be_clr. Three instances
//                (READ_FIRST/latency 1, WRITE_FIRST/latency 2,
//                NO_CHANGE/latency 1) share one stimulus stream and are
//                compared every cycle against a word-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_be_clr;

    localparam int          c_DEPTH = 64;
    localparam int          c_N     = 3;
    localparam logic [15:0] c_CLR   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [1:0]  be;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic        clr;

    logic        ready_o    [c_N];
    logic        rvalid_o   [c_N];
    logic        clr_done_o [c_N];
    logic [15:0] rdata_o    [c_N];

    int lat_m  [c_N] = '{1, 2, 1};
    int mode_m [c_N] = '{0, 1, 2};

    // reference model state
    logic [15:0] mem [c_DEPTH];
    int          clr_cnt;
    logic        exp_ready;
    logic        exp_done;
    logic        exp_v  [c_N];
    logic [15:0] exp_d  [c_N];
    logic        pend_v [c_N];
    logic [15:0] pend_d [c_N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sp_ram_be_clr #(.RDW_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .clr(clr), .ready(ready_o[0]), .rdata(rdata_o[0]),
        .rvalid(rvalid_o[0]), .clr_done(clr_done_o[0]));

    sp_ram_be_clr #(.RDW_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .clr(clr), .ready(ready_o[1]), .rdata(rdata_o[1]),
        .rvalid(rvalid_o[1]), .clr_done(clr_done_o[1]));

    sp_ram_be_clr #(.RDW_MODE(2), .OUT_REG(0)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .clr(clr), .ready(ready_o[2]), .rdata(rdata_o[2]),
        .rvalid(rvalid_o[2]), .clr_done(clr_done_o[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] b);
        logic [15:0] r;
        r = o;
        if (b[0]) r[7:0]  = n[7:0];
        if (b[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs held across it
    task automatic model_edge();
        logic [15:0] old_w;
        logic [15:0] new_w;
        logic        res_v [c_N];
        logic [15:0] res_d [c_N];
        logic        kill;
        kill = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            res_v[i] = 1'b0;
            res_d[i] = '0;
        end
        if (rst) begin
            clr_cnt  = c_DEPTH;
            exp_done = 1'b0;
            for (int i = 0; i < c_N; i++) begin
                pend_v[i] = 1'b0;
                exp_v[i]  = 1'b0;
                exp_d[i]  = '0;
            end
        end else begin
            exp_done = 1'b0;
            if (clr_cnt > 0) begin
                mem[c_DEPTH - clr_cnt] = c_CLR;
                clr_cnt--;
                if (clr_cnt == 0) exp_done = 1'b1;
            end else if (clr) begin
                clr_cnt = c_DEPTH;
                kill    = 1'b1;
            end else if (en) begin
                old_w = mem[addr];
                new_w = merge(old_w, wdata, be);
                if (we) mem[addr] = new_w;
                for (int i = 0; i < c_N; i++) begin
                    if (!we) begin
                        res_v[i] = 1'b1; res_d[i] = old_w;
                    end else if (mode_m[i] == 0) begin
                        res_v[i] = 1'b1; res_d[i] = old_w;
                    end else if (mode_m[i] == 1) begin
                        res_v[i] = 1'b1; res_d[i] = new_w;
                    end
                end
            end
            for (int i = 0; i < c_N; i++) begin
                if (lat_m[i] == 1) begin
                    exp_v[i] = res_v[i];
                    if (res_v[i]) exp_d[i] = res_d[i];
                end else begin
                    exp_v[i] = pend_v[i] && !kill;
                    if (exp_v[i]) exp_d[i] = pend_d[i];
                    pend_v[i] = res_v[i];
                    pend_d[i] = res_d[i];
                end
            end
        end
        exp_ready = (clr_cnt == 0);
    endtask

    task automatic check_outputs();
        for (int i = 0; i < c_N; i++) begin
            chk($sformatf("ready%0d", i),    32'(ready_o[i]),    32'(exp_ready));
            chk($sformatf("clr_done%0d", i), 32'(clr_done_o[i]), 32'(exp_done));
            chk($sformatf("rvalid%0d", i),   32'(rvalid_o[i]),   32'(exp_v[i]));
            chk($sformatf("rdata%0d", i),    32'(rdata_o[i]),    32'(exp_d[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_outputs();
    endtask

    task automatic access(input logic e, input logic w, input logic [1:0] b,
                          input logic [5:0] a, input logic [15:0] d);
        en = e; we = w; be = b; addr = a; wdata = d; clr = 1'b0;
        step();
    endtask

    // Count cycles until ready rises; a clear should take exactly DEPTH cycles
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready_o[0] && n < 300) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'd64);
    endtask

    initial begin
        int nv;
        for (int i = 0; i < c_DEPTH; i++) mem[i] = '0;
        rst = 1'b1; en = 1'b0; we = 1'b0; be = 2'b00; addr = '0; wdata = '0; clr = 1'b0;

        // 1. reset then power-up clear
        repeat (3) step();
        rst = 1'b0;
        wait_ready("reset_clear_len");
        for (int a = 0; a < c_DEPTH; a++) access(1'b1, 1'b0, 2'b00, 6'(a), 16'h0);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);

        // 2. byte lanes
        access(1'b1, 1'b1, 2'b11, 6'd5, 16'hA5A5);
        access(1'b1, 1'b1, 2'b10, 6'd5, 16'h3C00);
        access(1'b1, 1'b0, 2'b00, 6'd5, 16'h0);
        chk("lane_merge_l1", 32'(rdata_o[0]), 32'h3CA5);
        chk("lane_valid_l1", 32'(rvalid_o[0]), 32'd1);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        chk("lane_merge_l2", 32'(rdata_o[1]), 32'h3CA5);
        chk("lane_valid_l2", 32'(rvalid_o[1]), 32'd1);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);

        // 3. read-during-write modes
        access(1'b1, 1'b1, 2'b11, 6'd9, 16'h1111);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        access(1'b1, 1'b1, 2'b11, 6'd9, 16'h2222);
        chk("rdw_rf_data", 32'(rdata_o[0]), 32'h1111);
        chk("rdw_rf_valid", 32'(rvalid_o[0]), 32'd1);
        chk("rdw_nc_valid", 32'(rvalid_o[2]), 32'd0);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        chk("rdw_wf_data", 32'(rdata_o[1]), 32'h2222);
        chk("rdw_wf_valid", 32'(rvalid_o[1]), 32'd1);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);

        // 4. streaming writes then reads
        for (int a = 0; a < c_DEPTH; a++) access(1'b1, 1'b1, 2'b11, 6'(a), 16'(a) ^ 16'hFFFF);
        nv = 0;
        for (int a = 0; a < c_DEPTH; a++) begin
            access(1'b1, 1'b0, 2'b00, 6'(a), 16'h0);
            if (rvalid_o[0]) nv++;
        end
        chk("stream_pulses", 32'(nv), 32'd64);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);

        // 5. runtime clear with a colliding write
        for (int a = 0; a < c_DEPTH; a++) access(1'b1, 1'b1, 2'b11, 6'(a), 16'hBEEF);
        en = 1'b1; we = 1'b1; be = 2'b11; addr = 6'd0; wdata = 16'h1234; clr = 1'b1;
        step();
        clr = 1'b0;
        wait_ready("rtclr_len");
        access(1'b1, 1'b0, 2'b00, 6'd0, 16'h0);
        chk("rtclr_addr0", 32'(rdata_o[0]), 32'(c_CLR));
        for (int a = 1; a < c_DEPTH; a++) access(1'b1, 1'b0, 2'b00, 6'(a), 16'h0);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);

        // 6. reset in the middle of a clear, with reads requested throughout
        en = 1'b0; we = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 30; k++) begin
            en = 1'b1; we = 1'($urandom); addr = 6'($urandom); be = 2'($urandom);
            clr = 1'($urandom);
            step();
        end
        clr = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        en = 1'b1; we = 1'b0;
        wait_ready("rst_mid_len");
        access(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);

        // 7. randomized traffic with occasional clears and resets
        for (int k = 0; k < 1500; k++) begin
            en    = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom);
            be    = 2'($urandom);
            addr  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            wdata = 16'($urandom);
            clr   = ($urandom_range(0, 149) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; clr = 1'b0; en = 1'b0;
        repeat (70) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
